// File: rtl/apb_master_bridge.sv
// APB4 requester bridge: commands are buffered in a small FIFO and issued one at a
// time as APB transfers; each result is held in a single response register.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int CMD_DEPTH      = 2,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR,
   output logic [7:0]            err_cnt
);

   localparam int PW = $clog2(CMD_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(CMD_DEPTH);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } cmd_t;

   cmd_t          fifo_mem [CMD_DEPTH];
   cmd_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          out_of_reset;
   logic [TW-1:0] tmo_cnt;
   state_t        state, state_nxt;
   logic          push, pop, done, abort, start;

   assign cmd_ready = out_of_reset && (count < FULL_CNT);
   assign push      = cmd_valid && cmd_ready;
   assign head      = fifo_mem[rd_ptr];
   assign done      = (state == ACCESS) && PREADY;
   assign abort     = (state == ACCESS) && !PREADY && (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LIMIT);
   assign pop       = done || abort;
   assign PSEL      = (state != IDLE);
   assign PENABLE   = (state == ACCESS);

   // NOTE: FIFO storage has no reset; the empty count guards stale entries, so only
   // control state needs clearing and the array can map onto plain registers/RAM.
   always_ff @(posedge PCLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         out_of_reset <= 1'b0;
      end else begin
         out_of_reset <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && !rsp_valid) begin
               state_nxt = SETUP;
               start     = 1'b1;
            end
         end
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state   <= IDLE;
         tmo_cnt <= '0;
         PADDR   <= '0;
         PWRITE  <= 1'b0;
         PWDATA  <= '0;
         PSTRB   <= '0;
      end else begin
         state <= state_nxt;
         // Payload is captured once at SETUP entry; later pushes cannot disturb it.
         if (start) begin
            PADDR  <= head.addr;
            PWRITE <= head.write;
            PWDATA <= head.wdata;
            PSTRB  <= head.write ? head.strb : '0;
         end
         if (state == SETUP) begin
            tmo_cnt <= '0;
         end else if ((state == ACCESS) && !PREADY && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         err_cnt     <= '0;
      end else begin
         if (done) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (((done && PSLVERR) || abort) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule
